maxpool2x2_axis: RTL and testbench

//  Streaming 2x2/stride-2 max-pool stage placed directly downstream of the convolution AXI-Stream block.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/maxpool2x2_axis_if.sv | 23 ++
 rtl/maxpool2x2_axis_line_buf.sv | 34 +++
 rtl/maxpool2x2_axis.sv | 152 +++++++++++++++
 tb/tb_maxpool2x2_axis.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// +--------------------------------------------------------------------+
// | cnn_pkg: shared CNN datapath defaults, pixel type and signed max.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;

   localparam int CNN_DATA_RES = 8;
   localparam int CNN_MAP_DIM  = 26;

   typedef logic signed [CNN_DATA_RES-1:0] pixel_t;

   function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool2x2_axis_if.sv
// +--------------------------------------------------------------------+
// | maxpool2x2_axis_if: AXI-Stream data/valid/last/ready bundle.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface maxpool2x2_axis_if
   import cnn_pkg::*;
#(
   parameter int DATA_RES = CNN_DATA_RES
) ();

   logic [DATA_RES-1:0] tdata;
   logic                tvalid;
   logic                tlast;
   logic                tready;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

`default_nettype wire

// File: rtl/maxpool2x2_axis_line_buf.sv
// +--------------------------------------------------------------------+
// | pool_line_buf: half-width line buffer of vertical partial maxima,  |
// | async read, sync write, no reset. Revision: 1.0                    |
// +--------------------------------------------------------------------+
`default_nettype none

module pool_line_buf
   import cnn_pkg::*;
#(
   parameter int DATA_RES = CNN_DATA_RES,
   parameter int DEPTH    = 13,
   parameter int AW       = 4
) (
   input  wire logic                clk_i,
   input  wire logic                we_i,
   input  wire logic [AW-1:0]       waddr_i,
   input  wire logic [DATA_RES-1:0] wdata_i,
   input  wire logic [AW-1:0]       raddr_i,
   output logic      [DATA_RES-1:0] rdata_o
);

   logic [DATA_RES-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/maxpool2x2_axis.sv
// +--------------------------------------------------------------------+
// | maxpool2x2_axis: streaming 2x2/stride-2 signed max-pool with tlast |
// | frame check. Optional macro RELU_EN clamps negative inputs to 0.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module maxpool2x2_axis
   import cnn_pkg::*;
#(
   parameter int DATA_RES = CNN_DATA_RES,
   parameter int MAP_DIM  = CNN_MAP_DIM
) (
   input  wire logic        clk_i,
   input  wire logic        resetn_i,
   maxpool2x2_axis_if.slave  s_axis,
   maxpool2x2_axis_if.master m_axis,
   output logic             frame_err_o
);

   localparam int OUT_DIM = MAP_DIM / 2;
   localparam int CW      = $clog2(MAP_DIM);
   localparam int AW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam bit ODD_DIM = (MAP_DIM % 2) == 1;
   localparam logic [CW-1:0] LAST_IDX  = CW'(MAP_DIM - 1);
   localparam logic [CW-1:0] POOL_LAST = CW'(2 * OUT_DIM - 1);

   typedef logic signed [DATA_RES-1:0] spix_t;

   function automatic spix_t smax(input spix_t a, input spix_t b);
      return (a > b) ? a : b;
   endfunction

   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   spix_t         hold_q, hold_d;
   spix_t         out_q, out_d;
   logic          out_vld_q, out_vld_d;
   logic          out_last_q, out_last_d;
   logic          err_q, err_d;

   logic          w_accept;
   logic          w_keep;
   logic          w_last_pix;
   spix_t         w_x;
   spix_t         w_lbuf_rd;
   spix_t         w_lbuf_wd;
   logic          w_lbuf_we;
   logic [AW-1:0] w_cp;

   assign s_axis.tready = !out_vld_q || m_axis.tready;
   assign w_accept      = s_axis.tvalid && s_axis.tready;
   assign w_last_pix    = (row_q == LAST_IDX) && (col_q == LAST_IDX);
   // Floor pooling: the trailing row/column of an odd map is consumed but ignored.
   assign w_keep        = !(ODD_DIM && ((row_q == LAST_IDX) || (col_q == LAST_IDX)));
   assign w_cp          = AW'(col_q >> 1);

`ifdef RELU_EN
   assign w_x = s_axis.tdata[DATA_RES-1] ? '0 : $signed(s_axis.tdata);
`else
   assign w_x = $signed(s_axis.tdata);
`endif

   pool_line_buf #(
      .DATA_RES (DATA_RES),
      .DEPTH    (OUT_DIM),
      .AW       (AW)
   ) u_line_buf (
      .clk_i    (clk_i),
      .we_i     (w_lbuf_we),
      .waddr_i  (w_cp),
      .wdata_i  (w_lbuf_wd),
      .raddr_i  (w_cp),
      .rdata_o  (w_lbuf_rd)
   );

   always_comb begin
      row_d      = row_q;
      col_d      = col_q;
      hold_d     = hold_q;
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      err_d      = 1'b0;
      w_lbuf_we  = 1'b0;
      w_lbuf_wd  = smax(hold_q, w_x);

      if (m_axis.tready) begin
         out_vld_d = 1'b0;
      end

      if (w_accept) begin
         if (w_keep) begin
            unique case ({row_q[0], col_q[0]})
               2'b00: hold_d    = w_x;
               2'b01: w_lbuf_we = 1'b1;
               2'b10: hold_d    = smax(w_lbuf_rd, w_x);
               default: begin
                  out_d      = smax(hold_q, w_x);
                  out_vld_d  = 1'b1;
                  out_last_d = (row_q == POOL_LAST) && (col_q == POOL_LAST);
               end
            endcase
         end

         // Early tlast resyncs to the frame start; a missing tlast only flags.
         if (s_axis.tlast && !w_last_pix) begin
            err_d = 1'b1;
            row_d = '0;
            col_d = '0;
         end else begin
            if (!s_axis.tlast && w_last_pix) begin
               err_d = 1'b1;
            end
            if (col_q == LAST_IDX) begin
               col_d = '0;
               row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         row_q      <= '0;
         col_q      <= '0;
         hold_q     <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         hold_q     <= hold_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         err_q      <= err_d;
      end
   end

   assign m_axis.tdata  = out_q;
   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tlast  = out_last_q;
   assign frame_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_maxpool2x2_axis.sv
// +--------------------------------------------------------------------+
// | tb_maxpool2x2_axis: three pool instances (4x4, 5x5, 26x26) checked |
// | against a frame-level reference model. Revision: 1.0               |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_maxpool2x2_axis;
   import cnn_pkg::*;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic [7:0] s_tdata  [NDUT];
   logic       s_tvalid [NDUT];
   logic       s_tlast  [NDUT];
   logic       s_tready [NDUT];
   logic [7:0] m_tdata  [NDUT];
   logic       m_tvalid [NDUT];
   logic       m_tlast  [NDUT];
   logic       m_tready [NDUT];
   logic       ferr     [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int MD = (g == 0) ? 4 : ((g == 1) ? 5 : 26);
      maxpool2x2_axis_if #(.DATA_RES(8)) s_if ();
      maxpool2x2_axis_if #(.DATA_RES(8)) m_if ();
      assign s_if.tdata   = s_tdata[g];
      assign s_if.tvalid  = s_tvalid[g];
      assign s_if.tlast   = s_tlast[g];
      assign s_tready[g]  = s_if.tready;
      assign m_tdata[g]   = m_if.tdata;
      assign m_tvalid[g]  = m_if.tvalid;
      assign m_tlast[g]   = m_if.tlast;
      assign m_if.tready  = m_tready[g];
      maxpool2x2_axis #(.DATA_RES(8), .MAP_DIM(MD)) u_dut (
         .clk_i       (clk),
         .resetn_i    (resetn),
         .s_axis      (s_if),
         .m_axis      (m_if),
         .frame_err_o (ferr[g])
      );
   end

   int         total = 0;
   int         bad   = 0;
   logic [7:0] px [0:675];
   int         exp_v [NDUT][512];
   bit         exp_l [NDUT][512];
   int         wr [NDUT];
   int         rd [NDUT];
   int         outs [NDUT];
   int         errs [NDUT];
   bit         stall [NDUT];
   logic [7:0] held  [NDUT];
   logic       heldl [NDUT];
   bit         rnd_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int pix_val(input logic [7:0] v);
`ifdef RELU_EN
      if (v[7]) return 0;
`endif
      return int'($signed(v));
   endfunction

   // Expected outputs: every 2x2 block whose bottom-right pixel lies among the first cnt beats.
   task automatic model_frame(input int k, input int n, input int cnt);
      int o = n / 2;
      for (int i = 0; i < o; i++) begin
         for (int j = 0; j < o; j++) begin
            if ((2*i+1)*n + 2*j+1 < cnt) begin
               int m = pix_val(px[2*i*n + 2*j]);
               if (pix_val(px[2*i*n + 2*j+1])     > m) m = pix_val(px[2*i*n + 2*j+1]);
               if (pix_val(px[(2*i+1)*n + 2*j])   > m) m = pix_val(px[(2*i+1)*n + 2*j]);
               if (pix_val(px[(2*i+1)*n + 2*j+1]) > m) m = pix_val(px[(2*i+1)*n + 2*j+1]);
               exp_v[k][wr[k]] = m;
               exp_l[k][wr[k]] = (i == o-1) && (j == o-1);
               wr[k]++;
            end
         end
      end
   endtask

   task automatic send(input int k, input logic [7:0] d, input logic last);
      bit acc = 1'b0;
      s_tdata[k]  = d;
      s_tvalid[k] = 1'b1;
      s_tlast[k]  = last;
      for (int n = 0; n < 400 && !acc; n++) begin
         @(negedge clk);
         acc = s_tready[k];
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: dut %0d beat not accepted, got 0 want 1", k);
      end
      s_tvalid[k] = 1'b0;
      s_tlast[k]  = 1'b0;
   endtask

   task automatic send_frame(input int k, input int cnt, input int last_at);
      for (int i = 0; i < cnt; i++) send(k, px[i], i == last_at);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 3000 && !done; n++) begin
         done = 1'b1;
         for (int k = 0; k < NDUT; k++) if (rd[k] != wr[k]) done = 1'b0;
         if (!done) begin
            @(posedge clk);
            #1;
         end
      end
      for (int k = 0; k < NDUT; k++) chk("drain_count", rd[k], wr[k]);
   endtask

   initial begin
      int base;
      resetn = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         s_tdata[k] = '0; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0; m_tready[k] = 1'b1;
         wr[k] = 0; rd[k] = 0; outs[k] = 0; errs[k] = 0; stall[k] = 1'b0;
         held[k] = '0; heldl[k] = 1'b0;
      end

      fork
         forever begin
            @(negedge clk);
            if (!resetn) begin
               for (int k = 0; k < NDUT; k++) stall[k] = 1'b0;
            end else begin
               for (int k = 0; k < NDUT; k++) begin
                  chk("s_tready", s_tready[k], int'(!m_tvalid[k] || m_tready[k]));
                  if (stall[k]) begin
                     chk("stall_valid", m_tvalid[k], 1);
                     chk("stall_data", m_tdata[k], held[k]);
                     chk("stall_last", m_tlast[k], heldl[k]);
                  end
                  if (m_tvalid[k] && m_tready[k]) begin
                     if (rd[k] < wr[k]) begin
                        chk("out_data", int'($signed(m_tdata[k])), exp_v[k][rd[k]]);
                        chk("out_last", m_tlast[k], exp_l[k][rd[k]]);
                        rd[k]++;
                     end else begin
                        total++;
                        bad++;
                        $display("FAIL extra_output: dut %0d data %0d, no output expected", k, m_tdata[k]);
                     end
                     outs[k]++;
                  end
                  stall[k] = m_tvalid[k] && !m_tready[k];
                  held[k]  = m_tdata[k];
                  heldl[k] = m_tlast[k];
                  if (ferr[k]) errs[k]++;
               end
            end
         end
         forever begin
            @(posedge clk);
            #1;
            if (rnd_en) m_tready[2] = 1'($urandom_range(0, 1));
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_tvalid", m_tvalid[k], 0);
         chk("rst_tdata",  m_tdata[k], 0);
         chk("rst_tlast",  m_tlast[k], 0);
         chk("rst_ferr",   ferr[k], 0);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // 4x4 ramp: 5,7,13,15 with tlast on 15, valid one cycle after pixel 15.
      for (int i = 0; i < 16; i++) px[i] = 8'(i);
      base = wr[0];
      model_frame(0, 4, 16);
      chk("pin4_0", exp_v[0][base],   5);
      chk("pin4_1", exp_v[0][base+1], 7);
      chk("pin4_2", exp_v[0][base+2], 13);
      chk("pin4_3", exp_v[0][base+3], 15);
      chk("pin4_l0", int'(exp_l[0][base]), 0);
      chk("pin4_l3", int'(exp_l[0][base+3]), 1);
      send_frame(0, 16, 15);
      chk("lat_valid", m_tvalid[0], 1);
      chk("lat_data",  m_tdata[0], 15);
      chk("lat_last",  m_tlast[0], 1);

      // 5x5 ramp: last row/column dropped.
      for (int i = 0; i < 25; i++) px[i] = 8'(i);
      base = wr[1];
      model_frame(1, 5, 25);
      chk("pin5_0", exp_v[1][base],   6);
      chk("pin5_1", exp_v[1][base+1], 8);
      chk("pin5_2", exp_v[1][base+2], 16);
      chk("pin5_3", exp_v[1][base+3], 18);
      chk("pin5_l3", int'(exp_l[1][base+3]), 1);
      send_frame(1, 25, 24);
      drain();

      // 26x26 ramp with random backpressure.
      for (int i = 0; i < 676; i++) px[i] = 8'(i);
      model_frame(2, 26, 676);
      rnd_en = 1'b1;
      send_frame(2, 676, 675);
      drain();
      rnd_en = 1'b0;
      m_tready[2] = 1'b1;
      chk("count26", outs[2], 169);

      // All -3 frame: raw max is -3, clamped max is 0.
      for (int i = 0; i < 16; i++) px[i] = 8'hFD;
      base = wr[0];
      model_frame(0, 4, 16);
`ifdef RELU_EN
      chk("pin_relu", exp_v[0][base], 0);
`else
      chk("pin_neg", exp_v[0][base], -3);
`endif
      send_frame(0, 16, 15);
      drain();

      // Early tlast on pixel 9, then a clean frame.
      for (int i = 0; i < 16; i++) px[i] = 8'(i);
      base = wr[0];
      model_frame(0, 4, 10);
      chk("trunc_count", wr[0] - base, 2);
      send_frame(0, 10, 9);
      model_frame(0, 4, 16);
      send_frame(0, 16, 15);
      drain();
      chk("err_early", errs[0], 1);

      // Missing tlast on pixel 15: outputs unchanged, error flagged.
      model_frame(0, 4, 16);
      send_frame(0, 16, -1);
      drain();
      chk("err_missing", errs[0], 2);

      // Reset mid-frame with a stalled output pending.
      m_tready[0] = 1'b0;
      model_frame(0, 4, 6);
      send_frame(0, 6, -1);
      chk("pend_valid", m_tvalid[0], 1);
      s_tdata[0]  = px[6];
      s_tvalid[0] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", m_tvalid[0], 0);
      chk("mid_rst_data",  m_tdata[0], 0);
      for (int k = 0; k < NDUT; k++) rd[k] = wr[k];
      s_tvalid[0] = 1'b0;
      m_tready[0] = 1'b1;
      @(negedge clk);
      #2;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      model_frame(0, 4, 16);
      send_frame(0, 16, 15);
      drain();

      chk("outs0", outs[0], 22);
      chk("outs1", outs[1], 4);
      chk("errs0", errs[0], 2);
      chk("errs1", errs[1], 0);
      chk("errs2", errs[2], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
